// File: rtl/fifo_sched_pkg.sv
// -----------------------------------------------------------------------------
// fifo_sched_pkg
// Shared definitions for the round-robin result-FIFO scheduler:
//   - default sizing constants (block count, word width, index width)
//   - scheduler state encoding
//   - next_idx(): 1-based wrapping increment used for the round-robin pointer
// -----------------------------------------------------------------------------
package fifo_sched_pkg;

    localparam int NUM_BLOCKS_DEF = 24;
    localparam int WORD_BITS_DEF  = 32;
    localparam int IDX_BITS_DEF   = 5;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    // Block indices run 1..num, so the successor of num is 1, not 0.
    function automatic int unsigned next_idx(input int unsigned idx, input int unsigned num);
        return (idx >= num) ? 1 : idx + 1;
    endfunction

endpackage

// File: rtl/fifo_sched_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker. Finds the first set request at or after
// ptr_i, wrapping from NUM_BLOCKS back to 1.
// Ports:
//   req_i  [NUM_BLOCKS:1]  request vector (1 = block has a word)
//   ptr_i  [IDX_BITS-1:0]  1-based search start position
//   any_o                  at least one request is set
//   idx_o  [IDX_BITS-1:0]  1-based index of the chosen request (0 if none)
// -----------------------------------------------------------------------------
module rr_pick #(
    parameter int NUM_BLOCKS = 24,
    parameter int IDX_BITS   = 5
) (
    input  logic [NUM_BLOCKS:1]  req_i,
    input  logic [IDX_BITS-1:0]  ptr_i,
    output logic                 any_o,
    output logic [IDX_BITS-1:0]  idx_o
);

    logic [NUM_BLOCKS-1:0]   req0;    // zero-based copy of the request vector
    logic [2*NUM_BLOCKS-1:0] dbl;     // doubled so a right shift is a rotation
    logic [NUM_BLOCKS-1:0]   rot;     // rot[0] corresponds to block ptr_i
    logic [IDX_BITS-1:0]     base;

    assign req0 = req_i;
    assign base = (ptr_i == '0) ? '0 : ptr_i - 1'b1;
    assign dbl  = {req0, req0} >> base;
    assign rot  = dbl[NUM_BLOCKS-1:0];

    // Lowest set bit of the rotated vector, then map the offset back to a
    // 1-based block index.
    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned; otherwise synthesis would infer a latch.
    always_comb begin
        any_o = 1'b0;
        idx_o = '0;
        for (int k = 0; k < NUM_BLOCKS; k++) begin
            if (!any_o && rot[k]) begin
                any_o = 1'b1;
                idx_o = IDX_BITS'(((int'(base) + k) % NUM_BLOCKS) + 1);
            end
        end
    end

endmodule

// File: rtl/fifo_sched.sv
// -----------------------------------------------------------------------------
// fifo_sched
// Round-robin scheduler draining per-hash-block output FIFOs bit-serially and
// handing each complete word to the packet builder over valid/ready.
// States: IDLE (pick next block) -> SHIFT (WORD_BITS strobes) -> HOLD (offer).
// Ports (all in the mii_clk domain):
//   mii_clk, mii_rst_n      clock, asynchronous active-low reset
//   sched_en                permits new grants (sampled in IDLE only)
//   fifo_empty/oflow/bits   per-block FIFO status and head bit [NUM_BLOCKS:1]
//   fifo_req                one-hot shift strobe to the granted FIFO
//   out_valid/out_ready     word handshake
//   out_block               1-based source block of the offered word
//   out_data                word, first shifted bit in the MSB
//   out_oflow               overflow status of the source block
//   busy                    high in SHIFT or HOLD
// Build option: FIFO_SCHED_OFLOW_STICKY_EN -- per-block sticky overflow bits
// that clear on the accepting handshake; otherwise out_oflow is the live
// fifo_oflow of the granted block sampled at grant time.
// -----------------------------------------------------------------------------
module fifo_sched
    import fifo_sched_pkg::*;
#(
    parameter int NUM_BLOCKS = NUM_BLOCKS_DEF,
    parameter int WORD_BITS  = WORD_BITS_DEF,
    parameter int IDX_BITS   = IDX_BITS_DEF
) (
    input  logic                  mii_clk,
    input  logic                  mii_rst_n,
    input  logic                  sched_en,
    input  logic [NUM_BLOCKS:1]   fifo_empty,
    input  logic [NUM_BLOCKS:1]   fifo_oflow,
    input  logic [NUM_BLOCKS:1]   fifo_bits,
    output logic [NUM_BLOCKS:1]   fifo_req,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [IDX_BITS-1:0]   out_block,
    output logic [WORD_BITS-1:0]  out_data,
    output logic                  out_oflow,
    output logic                  busy
);

    localparam int CNT_BITS = $clog2(WORD_BITS + 1);

    state_t                 state_q, state_d;
    logic [IDX_BITS-1:0]    ptr_q,   ptr_d;
    logic [IDX_BITS-1:0]    grant_q, grant_d;
    logic [CNT_BITS-1:0]    cnt_q,   cnt_d;
    logic [WORD_BITS-1:0]   shreg_q, shreg_d;
    logic [NUM_BLOCKS:1]    req_q,   req_d;
    logic                   valid_q, valid_d;
    logic                   busy_q,  busy_d;
    logic                   oflow_q, oflow_d;

    logic                   pick_any;
    logic [IDX_BITS-1:0]    pick_idx;
    logic [NUM_BLOCKS:1]    req_vec;
    logic                   start;
    logic                   handshake;

    assign req_vec   = ~fifo_empty;
    assign start     = (state_q == ST_IDLE) && sched_en && pick_any;
    assign handshake = (state_q == ST_HOLD) && out_ready;

    rr_pick #(
        .NUM_BLOCKS (NUM_BLOCKS),
        .IDX_BITS   (IDX_BITS)
    ) u_pick (
        .req_i (req_vec),
        .ptr_i (ptr_q),
        .any_o (pick_any),
        .idx_o (pick_idx)
    );

    // Next-state / output logic. The strobe is launched from a register at
    // grant time, so fifo_req never depends combinationally on fifo_empty.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        grant_d = grant_q;
        cnt_d   = cnt_q;
        shreg_d = shreg_q;
        req_d   = req_q;
        valid_d = valid_q;
        busy_d  = busy_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    grant_d         = pick_idx;
                    cnt_d           = '0;
                    req_d           = '0;
                    req_d[pick_idx] = 1'b1;
                    busy_d          = 1'b1;
                    state_d         = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // fifo_empty is deliberately ignored here: a started word always
                // completes because blocks only expose whole words.
                shreg_d = {shreg_q[WORD_BITS-2:0], fifo_bits[grant_q]};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == CNT_BITS'(WORD_BITS - 1)) begin
                    req_d   = '0;
                    valid_d = 1'b1;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    busy_d  = 1'b0;
                    ptr_d   = IDX_BITS'(next_idx(32'(grant_q), NUM_BLOCKS));
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

`ifdef FIFO_SCHED_OFLOW_STICKY_EN
    logic [NUM_BLOCKS:1] sticky_q, sticky_d;

    // A new overflow in the handshake cycle wins over the clear.
    always_comb begin
        sticky_d = sticky_q | fifo_oflow;
        if (handshake) begin
            sticky_d[grant_q] = fifo_oflow[grant_q];
        end
    end

    // Track the sticky bit of whichever block the grant register will hold.
    always_comb begin
        oflow_d = 1'b0;
        if (grant_d != '0) begin
            oflow_d = sticky_d[grant_d];
        end
    end

    always_ff @(posedge mii_clk or negedge mii_rst_n) begin
        if (!mii_rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end
`else
    logic unused_hs;
    assign unused_hs = handshake;

    always_comb begin
        oflow_d = oflow_q;
        if (start) begin
            oflow_d = fifo_oflow[pick_idx];
        end
    end
`endif

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge mii_clk or negedge mii_rst_n) begin
        if (!mii_rst_n) begin
            state_q <= ST_IDLE;
            ptr_q   <= IDX_BITS'(1);
            grant_q <= '0;
            cnt_q   <= '0;
            shreg_q <= '0;
            req_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            oflow_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            grant_q <= grant_d;
            cnt_q   <= cnt_d;
            shreg_q <= shreg_d;
            req_q   <= req_d;
            valid_q <= valid_d;
            busy_q  <= busy_d;
            oflow_q <= oflow_d;
        end
    end

    assign fifo_req  = req_q;
    assign out_valid = valid_q;
    assign out_block = grant_q;
    assign out_data  = shreg_q;
    assign out_oflow = oflow_q;
    assign busy      = busy_q;

endmodule

// File: doc/fifo_sched.md
# fifo_sched

Round-robin scheduler that drains result words from the per-hash-block output FIFOs and presents them to the Ethernet read-out path. It sits between the 24 `block` instances (their `fifo_empty`/`fifo_oflow`/`fifo_req`/`fifo_bits` vectors) and the packet builder. It grants one non-empty FIFO at a time, shifts one word out bit-serially, and hands the word over with a valid/ready handshake. All logic runs in the `mii_clk` domain.

## Interface
Parameters:
- `NUM_BLOCKS`, 24: number of FIFO requesters, indexed 1..NUM_BLOCKS.
- `WORD_BITS`, 32: bits per result word.
- `IDX_BITS`, 5: width of the block index; must satisfy 2**IDX_BITS > NUM_BLOCKS.

Ports:
- `mii_clk`  in  1  sole clock.
- `mii_rst_n`  in  1  asynchronous, active-low reset.
- `sched_en`  in  1  permits new grants; 0 lets the current word finish, then idles.
- `fifo_empty`  in  [NUM_BLOCKS:1]  per-block FIFO empty flag.
- `fifo_oflow`  in  [NUM_BLOCKS:1]  per-block FIFO overflow flag (level).
- `fifo_bits`  in  [NUM_BLOCKS:1]  current head bit of each FIFO.
- `fifo_req`  out  [NUM_BLOCKS:1]  one-hot shift strobe; each high cycle consumes one bit.
- `out_valid`  out  1  word available.
- `out_ready`  in  1  consumer accepts the word when high together with out_valid.
- `out_block`  out  IDX_BITS  source block index, 1-based.
- `out_data`  out  WORD_BITS  word, first shifted bit in MSB.
- `out_oflow`  out  1  overflow status of the source block (see Configuration).
- `busy`  out  1  high in SHIFT or HOLD.

## Operation
- States are IDLE, SHIFT and HOLD. Reset state is IDLE with round-robin pointer `ptr` = 1.
- **IDLE**: if `sched_en` and any `fifo_empty[i]`==0, pick the first non-empty index at or after `ptr`, wrapping NUM_BLOCKS→1. Latch it as `grant`, sample `fifo_oflow[grant]`, clear the bit counter, go to SHIFT.
- **SHIFT**: `fifo_req[grant]`=1 every cycle. Each cycle shift `fifo_bits[grant]` into the LSB of the shift register and increment the counter. After WORD_BITS strobes, go to HOLD.
- **HOLD**: `out_valid`=1, and `out_data`/`out_block`/`out_oflow` are stable. On `out_valid && out_ready`, set `ptr` = grant+1 (wrapping NUM_BLOCKS→1) and go to IDLE.
- `fifo_empty[grant]` rising during SHIFT is ignored. Blocks only expose whole words, so a started word always completes.
- `sched_en` is sampled only in IDLE. Deasserting it never truncates SHIFT or HOLD.
- Bit counter width is $clog2(WORD_BITS+1); no wrap occurs within a word.
- Reset mid-SHIFT abandons the partial word. The consumer gets nothing, and the block FIFOs are reset alongside by the `fifo_rst` path.

## Timing
- All outputs reset to 0: `fifo_req`, `out_valid`, `out_block`, `out_data`, `out_oflow`, `busy`.
- All outputs are registered. `fifo_req` is driven from the state/grant registers, never combinationally from `fifo_empty`.
- Latency, non-empty to first strobe: `fifo_empty[i]` low at edge N (in IDLE) gives `fifo_req[i]` high from edge N+1.
- Shift duration is exactly WORD_BITS cycles. `out_valid` rises on the edge after the last strobe.
- Word-to-word minimum: a handshake at edge M returns to IDLE. The next grant is registered at M+1 and the next strobe is high from M+2. Throughput is one word per WORD_BITS+2 cycles with `out_ready` held high.
- `out_ready` may be high before `out_valid`; no combinational path exists from `out_ready` to `out_valid`.

## Configuration
- `FIFO_SCHED_OFLOW_STICKY_EN` defined:
  - A per-block sticky register sets on any cycle with `fifo_oflow[i]`=1.
  - `out_oflow` reports the sticky bit of `grant`.
  - That sticky bit clears on the accepting handshake, unless `fifo_oflow[grant]` is high in the same cycle, in which case set wins.
- Not defined: `out_oflow` is the live `fifo_oflow[grant]` sampled at grant time, and no sticky registers exist.

## Structure
- Package `fifo_sched_pkg` holds the state enum (IDLE/SHIFT/HOLD), the default NUM_BLOCKS/WORD_BITS/IDX_BITS constants, and a `next_idx` wrap function.
- Sub-module `rr_pick` is combinational. Inputs are the request vector (~`fifo_empty`) and `ptr`; outputs are `any` and the 1-based `idx`. It rotates, finds the lowest set bit, and un-rotates.

## Test plan
- Reset: hold `mii_rst_n`=0 with all FIFOs non-empty → all outputs 0. Release → `fifo_req[1]` high 2 cycles later, for exactly 32 cycles.
- Single word: only block 5 non-empty, head bits 0xA5C3_0F01 → `out_block`=5, `out_data`=0xA5C3_0F01, and `fifo_req[5]` pulsed 32 cycles.
- Fairness: blocks 3, 7 and 24 permanently non-empty with `out_ready`=1 → grant order 3,7,24,3,7,24. Gap between words is 2 cycles.
- Backpressure: `out_ready`=0 for 100 cycles in HOLD → `out_valid` and outputs stable, and `fifo_req` all 0.
- Enable: drop `sched_en` at bit 10 of a word → the word completes and is delivered, and no further `fifo_req` while low.
- Overflow: with `FIFO_SCHED_OFLOW_STICKY_EN`, pulse `fifo_oflow[9]` one cycle while idle, then fill block 9 → first word `out_oflow`=1, second word `out_oflow`=0. Without the macro → both 0.
